// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
// The controller takes the master side: it reads the stage fields and drives the stall, flush and forward controls.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs_d;
    logic [4:0]       rt_d;
    logic [4:0]       rs_e;
    logic [4:0]       rt_e;
    logic [4:0]       write_reg_e;
    logic [4:0]       write_reg_m;
    logic [4:0]       write_reg_w;
    logic             reg_write_e;
    logic             reg_write_m;
    logic             reg_write_w;
    logic             mem_to_reg_e;
    logic             mem_to_reg_m;
    logic             mem_write_m;
    logic             branch_d;
    logic             pcsrc_d;
    logic             mem_ready;

    logic             stall_f;
    logic             stall_d;
    logic             stall_e;
    logic             stall_m;
    logic             flush_d;
    logic             flush_e;
    logic             flush_w;
    logic             forward_a_d;
    logic             forward_b_d;
    logic [1:0]       forward_a_e;
    logic [1:0]       forward_b_e;
    logic             mem_fault;
    logic [CNT_W-1:0] hazard_stall_cnt;
    logic [CNT_W-1:0] mem_stall_cnt;

    modport master (
        input  rs_d, rt_d, rs_e, rt_e,
        input  write_reg_e, write_reg_m, write_reg_w,
        input  reg_write_e, reg_write_m, reg_write_w,
        input  mem_to_reg_e, mem_to_reg_m, mem_write_m,
        input  branch_d, pcsrc_d, mem_ready,
        output stall_f, stall_d, stall_e, stall_m,
        output flush_d, flush_e, flush_w,
        output forward_a_d, forward_b_d, forward_a_e, forward_b_e,
        output mem_fault, hazard_stall_cnt, mem_stall_cnt
    );

    modport slave (
        output rs_d, rt_d, rs_e, rt_e,
        output write_reg_e, write_reg_m, write_reg_w,
        output reg_write_e, reg_write_m, reg_write_w,
        output mem_to_reg_e, mem_to_reg_m, mem_write_m,
        output branch_d, pcsrc_d, mem_ready,
        input  stall_f, stall_d, stall_e, stall_m,
        input  flush_d, flush_e, flush_w,
        input  forward_a_d, forward_b_d, forward_a_e, forward_b_e,
        input  mem_fault, hazard_stall_cnt, mem_stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding selects, load-use/branch stalls,
// a memory-wait FSM with timeout fault, and saturating stall-cycle counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.master hz_if
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FAULT    = 2'b10
    } state_t;

    localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q,       state_d;
    logic [7:0]       wait_cnt_q,    wait_cnt_d;
    logic             mem_fault_q,   mem_fault_d;
    logic [CNT_W-1:0] hz_cnt_q,      hz_cnt_d;
    logic [CNT_W-1:0] mem_cnt_q,     mem_cnt_d;

    logic       lw_stall_s;
    logic       br_stall_s;
    logic       hz_s;
    logic       mem_access_s;
    logic       mem_stall_s;
    logic       stall_f_s, stall_d_s, stall_e_s, stall_m_s;
    logic       flush_d_s, flush_e_s, flush_w_s;
    logic       fwd_a_d_s, fwd_b_d_s;
    logic [1:0] fwd_a_e_s, fwd_b_e_s;

    // E-stage forwarding: M beats W; register 0 is never forwarded.
    always_comb begin
        fwd_a_e_s = 2'b00;
        fwd_b_e_s = 2'b00;
        if ((hz_if.rs_e != 5'd0) && (hz_if.rs_e == hz_if.write_reg_m) && hz_if.reg_write_m) begin
            fwd_a_e_s = 2'b10;
        end else if ((hz_if.rs_e != 5'd0) && (hz_if.rs_e == hz_if.write_reg_w) && hz_if.reg_write_w) begin
            fwd_a_e_s = 2'b01;
        end else begin
            fwd_a_e_s = 2'b00;
        end
        if ((hz_if.rt_e != 5'd0) && (hz_if.rt_e == hz_if.write_reg_m) && hz_if.reg_write_m) begin
            fwd_b_e_s = 2'b10;
        end else if ((hz_if.rt_e != 5'd0) && (hz_if.rt_e == hz_if.write_reg_w) && hz_if.reg_write_w) begin
            fwd_b_e_s = 2'b01;
        end else begin
            fwd_b_e_s = 2'b00;
        end
    end

    // D-stage branch-compare forwarding from the M-stage ALU result.
    always_comb begin
        fwd_a_d_s = (hz_if.rs_d != 5'd0) && (hz_if.rs_d == hz_if.write_reg_m) && hz_if.reg_write_m;
        fwd_b_d_s = (hz_if.rt_d != 5'd0) && (hz_if.rt_d == hz_if.write_reg_m) && hz_if.reg_write_m;
    end

    // Data-hazard and memory-wait terms.
    always_comb begin
        lw_stall_s   = hz_if.mem_to_reg_e &&
                       ((hz_if.rt_e == hz_if.rs_d) || (hz_if.rt_e == hz_if.rt_d));
        br_stall_s   = hz_if.branch_d &&
                       ((hz_if.reg_write_e &&
                         ((hz_if.write_reg_e == hz_if.rs_d) || (hz_if.write_reg_e == hz_if.rt_d))) ||
                        (hz_if.mem_to_reg_m &&
                         ((hz_if.write_reg_m == hz_if.rs_d) || (hz_if.write_reg_m == hz_if.rt_d))));
        hz_s         = lw_stall_s || br_stall_s;
        mem_access_s = hz_if.mem_to_reg_m || hz_if.mem_write_m;
        mem_stall_s  = mem_access_s && !hz_if.mem_ready;
    end

    // Pipeline register controls; a memory stall or fault freezes everything and bubbles MW.
    always_comb begin
        stall_f_s = 1'b0;
        stall_d_s = 1'b0;
        stall_e_s = 1'b0;
        stall_m_s = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        flush_w_s = 1'b0;
        if ((state_q == ST_FAULT) || mem_stall_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
            flush_w_s = 1'b1;
        end else if (hz_s) begin
            // A stalled D must keep its instruction, so a taken branch cannot flush it here.
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else begin
            flush_d_s = hz_if.pcsrc_d;
        end
    end

    // Next-state logic for the memory-wait FSM.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_fault_d = mem_fault_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall_s) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (hz_if.mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = ST_FAULT;
                    mem_fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_FAULT: begin
                state_d     = ST_FAULT;
                mem_fault_d = 1'b1;
            end
            default: begin
                state_d     = ST_RUN;
                wait_cnt_d  = 8'd0;
                mem_fault_d = 1'b0;
            end
        endcase
    end

    // Saturating performance counters; FAULT counts as memory stall time.
    always_comb begin
        hz_cnt_d  = hz_cnt_q;
        mem_cnt_d = mem_cnt_q;
        if (hz_s && !mem_stall_s && (state_q != ST_FAULT) && (hz_cnt_q != CNT_MAX)) begin
            hz_cnt_d = hz_cnt_q + CNT_ONE;
        end else begin
            hz_cnt_d = hz_cnt_q;
        end
        if ((mem_stall_s || (state_q == ST_FAULT)) && (mem_cnt_q != CNT_MAX)) begin
            mem_cnt_d = mem_cnt_q + CNT_ONE;
        end else begin
            mem_cnt_d = mem_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            mem_fault_q <= 1'b0;
            hz_cnt_q    <= '0;
            mem_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_fault_q <= mem_fault_d;
            hz_cnt_q    <= hz_cnt_d;
            mem_cnt_q   <= mem_cnt_d;
        end
    end

    assign hz_if.stall_f          = stall_f_s;
    assign hz_if.stall_d          = stall_d_s;
    assign hz_if.stall_e          = stall_e_s;
    assign hz_if.stall_m          = stall_m_s;
    assign hz_if.flush_d          = flush_d_s;
    assign hz_if.flush_e          = flush_e_s;
    assign hz_if.flush_w          = flush_w_s;
    assign hz_if.forward_a_d      = fwd_a_d_s;
    assign hz_if.forward_b_d      = fwd_b_d_s;
    assign hz_if.forward_a_e      = fwd_a_e_s;
    assign hz_if.forward_b_e      = fwd_b_e_s;
    assign hz_if.mem_fault        = mem_fault_q;
    assign hz_if.hazard_stall_cnt = hz_cnt_q;
    assign hz_if.mem_stall_cnt    = mem_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl with a short timeout and 2-bit counters.
module tb_pipeline_hazard_ctrl;
    localparam int TO = 4;
    localparam int CW = 2;

    // ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_HZ   = 7'b1100010;
    localparam logic [6:0] C_MEM  = 7'b1111001;
    localparam logic [6:0] C_BR   = 7'b0000100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hif ();
    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .hz_if(hif));

    typedef struct {
        string          tag;
        logic [6:0]     ctl;
        logic [5:0]     fwd;
        logic           fault;
        logic [CW-1:0]  hc;
        logic [CW-1:0]  mc;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic idle();
        hif.rs_d = 5'd0; hif.rt_d = 5'd0; hif.rs_e = 5'd0; hif.rt_e = 5'd0;
        hif.write_reg_e = 5'd0; hif.write_reg_m = 5'd0; hif.write_reg_w = 5'd0;
        hif.reg_write_e = 1'b0; hif.reg_write_m = 1'b0; hif.reg_write_w = 1'b0;
        hif.mem_to_reg_e = 1'b0; hif.mem_to_reg_m = 1'b0; hif.mem_write_m = 1'b0;
        hif.branch_d = 1'b0; hif.pcsrc_d = 1'b0; hif.mem_ready = 1'b0;
    endtask

    // Push the expectation for the cycle just driven, then pop and compare mid-cycle.
    task automatic chk(input string tag, input logic [6:0] ctl, input logic [5:0] fwd,
                       input logic fault, input logic [CW-1:0] hc, input logic [CW-1:0] mc);
        exp_t e;
        exp_t g;
        logic [6:0]      oc;
        logic [5:0]      ofw;
        logic [2*CW:0]   os;
        logic [2*CW:0]   es;
        e.tag = tag; e.ctl = ctl; e.fwd = fwd; e.fault = fault; e.hc = hc; e.mc = mc;
        sb.push_back(e);
        @(negedge clk);
        g   = sb.pop_front();
        oc  = {hif.stall_f, hif.stall_d, hif.stall_e, hif.stall_m, hif.flush_d, hif.flush_e, hif.flush_w};
        ofw = {hif.forward_a_d, hif.forward_b_d, hif.forward_a_e, hif.forward_b_e};
        os  = {hif.mem_fault, hif.hazard_stall_cnt, hif.mem_stall_cnt};
        es  = {g.fault, g.hc, g.mc};
        n_cmp++;
        assert (oc === g.ctl) else begin
            n_err++;
            $error("FAIL %s ctl observed=%b expected=%b", g.tag, oc, g.ctl);
        end
        n_cmp++;
        assert (ofw === g.fwd) else begin
            n_err++;
            $error("FAIL %s fwd observed=%b expected=%b", g.tag, ofw, g.fwd);
        end
        n_cmp++;
        assert (os === es) else begin
            n_err++;
            $error("FAIL %s fault_cnt observed=%b expected=%b", g.tag, os, es);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        idle();
        chk(tag, C_IDLE, 6'b000000, 1'b0, 2'd0, 2'd0);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        @(posedge clk);
        #1;
        chk("reset", C_IDLE, 6'b000000, 1'b0, 2'd0, 2'd0);
        rst = 1'b0;

        // Forwarding
        hif.rs_e = 5'd3; hif.write_reg_m = 5'd3; hif.reg_write_m = 1'b1;
        hif.write_reg_w = 5'd3; hif.reg_write_w = 1'b1;
        chk("fwd_m_prio", C_IDLE, 6'b001000, 1'b0, 2'd0, 2'd0);
        hif.rs_e = 5'd0; hif.rt_e = 5'd3; hif.rs_d = 5'd3; hif.mem_ready = 1'b1;
        chk("fwd_r0_bm_ad", C_IDLE, 6'b100010, 1'b0, 2'd0, 2'd0);
        hif.reg_write_m = 1'b0; hif.rs_e = 5'd3;
        chk("fwd_w_only", C_IDLE, 6'b000101, 1'b0, 2'd0, 2'd0);
        hif.write_reg_m = 5'd4; hif.reg_write_m = 1'b1; hif.write_reg_w = 5'd4;
        hif.rs_e = 5'd4; hif.rt_e = 5'd4; hif.rs_d = 5'd4; hif.rt_d = 5'd4;
        chk("fwd_all", C_IDLE, 6'b111010, 1'b0, 2'd0, 2'd0);

        // Load-use stalls
        idle(); hif.mem_to_reg_e = 1'b1; hif.rt_e = 5'd5; hif.rs_d = 5'd5;
        chk("lw_rs", C_HZ, 6'b000000, 1'b0, 2'd0, 2'd0);
        hif.mem_to_reg_e = 1'b0;
        chk("lw_release", C_IDLE, 6'b000000, 1'b0, 2'd1, 2'd0);
        idle(); hif.mem_to_reg_e = 1'b1; hif.rt_e = 5'd6; hif.rt_d = 5'd6; hif.pcsrc_d = 1'b1;
        chk("lw_rt_taken", C_HZ, 6'b000000, 1'b0, 2'd1, 2'd0);
        hif.mem_to_reg_e = 1'b0;
        chk("taken_flush", C_BR, 6'b000000, 1'b0, 2'd2, 2'd0);

        // Branch-in-decode stalls
        do_reset("reset_br");
        hif.branch_d = 1'b1; hif.pcsrc_d = 1'b1; hif.reg_write_e = 1'b1;
        hif.write_reg_e = 5'd7; hif.rs_d = 5'd7;
        chk("br_e", C_HZ, 6'b000000, 1'b0, 2'd0, 2'd0);
        idle(); hif.branch_d = 1'b1; hif.pcsrc_d = 1'b1; hif.mem_to_reg_m = 1'b1;
        hif.write_reg_m = 5'd8; hif.rt_d = 5'd8; hif.mem_ready = 1'b1;
        chk("br_m_zero_wait", C_HZ, 6'b000000, 1'b0, 2'd1, 2'd0);
        idle(); hif.pcsrc_d = 1'b1;
        chk("br_done", C_BR, 6'b000000, 1'b0, 2'd2, 2'd0);

        // Three-cycle memory wait with a concurrent load-use
        do_reset("reset_mw");
        hif.mem_to_reg_m = 1'b1; hif.mem_to_reg_e = 1'b1; hif.rt_e = 5'd5; hif.rs_d = 5'd5;
        chk("mw1", C_MEM, 6'b000000, 1'b0, 2'd0, 2'd0);
        chk("mw2", C_MEM, 6'b000000, 1'b0, 2'd0, 2'd1);
        chk("mw3", C_MEM, 6'b000000, 1'b0, 2'd0, 2'd2);
        hif.mem_ready = 1'b1; hif.mem_to_reg_e = 1'b0;
        chk("mw_ready", C_IDLE, 6'b000000, 1'b0, 2'd0, 2'd3);
        idle(); hif.mem_write_m = 1'b1; hif.mem_ready = 1'b1;
        chk("mw_zero_cycle", C_IDLE, 6'b000000, 1'b0, 2'd0, 2'd3);

        // Timeout to FAULT, then asynchronous reset out of it
        do_reset("reset_to");
        hif.mem_write_m = 1'b1;
        chk("to1", C_MEM, 6'b000000, 1'b0, 2'd0, 2'd0);
        chk("to2", C_MEM, 6'b000000, 1'b0, 2'd0, 2'd1);
        chk("to3", C_MEM, 6'b000000, 1'b0, 2'd0, 2'd2);
        chk("to4", C_MEM, 6'b000000, 1'b0, 2'd0, 2'd3);
        hif.mem_write_m = 1'b0;
        chk("fault_hold", C_MEM, 6'b000000, 1'b1, 2'd0, 2'd3);
        hif.mem_ready = 1'b1; hif.mem_to_reg_e = 1'b1; hif.rt_e = 5'd5; hif.rs_d = 5'd5;
        chk("fault_lw", C_MEM, 6'b000000, 1'b1, 2'd0, 2'd3);
        do_reset("fault_async_rst");

        // Hazard counter saturation
        hif.mem_to_reg_e = 1'b1; hif.rt_e = 5'd5; hif.rs_d = 5'd5;
        chk("sat1", C_HZ, 6'b000000, 1'b0, 2'd0, 2'd0);
        chk("sat2", C_HZ, 6'b000000, 1'b0, 2'd1, 2'd0);
        chk("sat3", C_HZ, 6'b000000, 1'b0, 2'd2, 2'd0);
        chk("sat4", C_HZ, 6'b000000, 1'b0, 2'd3, 2'd0);
        chk("sat5", C_HZ, 6'b000000, 1'b0, 2'd3, 2'd0);
        idle();
        chk("sat_hold", C_IDLE, 6'b000000, 1'b0, 2'd3, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
